// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM reader front-end button conditioning.
package rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        REPEATING = 2'd2
    } channel_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;     // 1 ms at 50 MHz
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;  // 0.5 s
    localparam int DEFAULT_REPEAT_PERIOD   = 5000000;   // 0.1 s

    localparam int CHIP_SEL = 2;
    localparam int INC      = 1;
    localparam int DEC      = 0;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchroniser, debounce counter and a
// press/auto-repeat FSM producing raw single-cycle press and repeat strobes.
module button_channel
    import rom_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter bit REPEAT_ENABLE   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    output logic       press_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [1:0] state_dbg
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             sync_q1, sync_q2, sync;
    logic             level;
    logic [DEB_W-1:0] deb_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic             delay_done, period_done;
    channel_state_t   state, state_next;

    // Synchroniser idles at 1 (released); sync is the active-high view.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= button;
            sync_q2 <= sync_q1;
        end
    end

    assign sync = ~sync_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            level   <= 1'b0;
            deb_cnt <= '0;
        end else if (sync == level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            level   <= sync;
            deb_cnt <= '0;
        end else if (deb_cnt != '1) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign delay_done  = (state == PRESSED)   && (rpt_cnt == DELAY_LAST);
    assign period_done = (state == REPEATING) && (rpt_cnt == PERIOD_LAST);

    // Repeat counter only runs while the button is debounced-held.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt <= '0;
        end else if (!REPEAT_ENABLE || !level || state == IDLE) begin
            rpt_cnt <= '0;
        end else if (delay_done || period_done) begin
            rpt_cnt <= '0;
        end else if (rpt_cnt != '1) begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (level) state_next = PRESSED;
            PRESSED: begin
                if (!level)                          state_next = IDLE;
                else if (REPEAT_ENABLE && delay_done) state_next = REPEATING;
            end
            REPEATING: if (!level) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        press_pulse  = (state == IDLE) && level;
        repeat_pulse = REPEAT_ENABLE && level && (delay_done || period_done);
        held         = level;
        state_dbg    = state;
    end

endmodule

// File: rtl/rom_button_conditioner.sv
// Conditions the chip-select / increment / decrement buttons into clean
// registered pulses, with an increment/decrement interlock.
module rom_button_conditioner
    import rom_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chip_selection_button,
    input  logic       increment_address_button,
    input  logic       decrement_address_button,
    output logic       chip_selection_pulse,
    output logic       increment_pulse,
    output logic       decrement_pulse,
    output logic [2:0] buttons_held,
    output logic [5:0] channel_state
);

    logic [2:0] raw_button, press, rpt, level;
    logic       both_press, both_held;
    logic       cs_next, inc_next, dec_next;

    assign raw_button[CHIP_SEL] = chip_selection_button;
    assign raw_button[INC]      = increment_address_button;
    assign raw_button[DEC]      = decrement_address_button;

    for (genvar i = 0; i < 3; i++) begin : g_channel
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_ENABLE  (i != CHIP_SEL)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .button      (raw_button[i]),
            .press_pulse (press[i]),
            .repeat_pulse(rpt[i]),
            .held        (level[i]),
            .state_dbg   (channel_state[2*i +: 2])
        );
    end

    // Simultaneous inc/dec presses cancel; repeats are muted while both are held.
    always_comb begin
        both_press = press[INC] & press[DEC];
        both_held  = level[INC] & level[DEC];
        cs_next    = press[CHIP_SEL] | rpt[CHIP_SEL];
        inc_next   = (press[INC] & ~both_press) | (rpt[INC] & ~both_held);
        dec_next   = (press[DEC] & ~both_press) | (rpt[DEC] & ~both_held);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chip_selection_pulse <= 1'b0;
            increment_pulse      <= 1'b0;
            decrement_pulse      <= 1'b0;
            buttons_held         <= 3'b000;
        end else begin
            chip_selection_pulse <= cs_next;
            increment_pulse      <= inc_next;
            decrement_pulse      <= dec_next;
            buttons_held         <= level;
        end
    end

endmodule

// File: tb/tb_rom_button_conditioner.sv
// Bench for rom_button_conditioner with short timing parameters: table of
// press scenarios plus hand-written bounce and reset sequences.
module tb_rom_button_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = DEB + 3;  // drive cycle to visible pulse

    logic       clk = 1'b0;
    logic       reset;
    logic       chip_selection_button, increment_address_button, decrement_address_button;
    logic       chip_selection_pulse, increment_pulse, decrement_pulse;
    logic [2:0] buttons_held;
    logic [5:0] channel_state;

    rom_button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .chip_selection_button   (chip_selection_button),
        .increment_address_button(increment_address_button),
        .decrement_address_button(decrement_address_button),
        .chip_selection_pulse    (chip_selection_pulse),
        .increment_pulse         (increment_pulse),
        .decrement_pulse         (decrement_pulse),
        .buttons_held            (buttons_held),
        .channel_state           (channel_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];  // {channel[1:0], cycle[29:0]}
    int          sc_d;
    int          sc_hold[3];
    bit          chk_held;
    int          pulse_cnt[3];

    typedef struct {
        int h_cs;
        int h_inc;
        int h_dec;
        int n_cs;
        int n_inc;
        int n_dec;
    } vec_t;

    vec_t vecs[9];

    function automatic bit held_exp(int ch, int n);
        if (sc_hold[ch] < DEB) return 1'b0;
        return (n >= sc_d + LAT) && (n < sc_d + sc_hold[ch] + LAT);
    endfunction

    function automatic bit pulse_exp(int ch, int n);
        int p;
        p = sc_d + LAT;
        if (!held_exp(ch, n)) return 1'b0;
        if (n == p)
            return !(ch != 2 && sc_hold[1] >= DEB && sc_hold[0] >= DEB);
        if (ch == 2 || n < p + RD || ((n - p - RD) % RP) != 0) return 1'b0;
        return !(held_exp(1, n) && held_exp(0, n));
    endfunction

    task automatic check_outputs();
        logic [2:0]  p;
        logic [2:0]  he;
        logic [31:0] want;
        p = {chip_selection_pulse, increment_pulse, decrement_pulse};
        while (exp_q.size() > 0 && int'(exp_q[0][29:0]) < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse: got none, expected ch%0d pulse at cycle %0d",
                     exp_q[0][31:30], exp_q[0][29:0]);
            void'(exp_q.pop_front());
        end
        for (int ch = 2; ch >= 0; ch--) begin
            if (p[ch] === 1'b1) begin
                pulse_cnt[ch]++;
                want = {2'(ch), 30'(cyc)};
                checks++;
                if (exp_q.size() > 0 && exp_q[0] == want) begin
                    void'(exp_q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL unexpected_pulse: got ch%0d pulse at cycle %0d, expected next %0h",
                             ch, cyc, (exp_q.size() > 0) ? exp_q[0] : 32'hffff_ffff);
                end
            end
        end
        if (chk_held) begin
            he = {held_exp(2, cyc), held_exp(1, cyc), held_exp(0, cyc)};
            checks++;
            if (buttons_held !== he) begin
                errors++;
                $display("FAIL buttons_held: cycle %0d got %b expected %b", cyc, buttons_held, he);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < 3; ch++) pulse_cnt[ch] = 0;
    endtask

    task automatic run_scenario(input int h_cs, input int h_inc, input int h_dec);
        int span;
        sc_d = cyc;
        sc_hold[2] = h_cs;
        sc_hold[1] = h_inc;
        sc_hold[0] = h_dec;
        span = h_cs;
        if (h_inc > span) span = h_inc;
        if (h_dec > span) span = h_dec;
        span = span + LAT + 8;
        for (int n = sc_d + 1; n <= sc_d + span; n++)
            for (int ch = 2; ch >= 0; ch--)
                if (pulse_exp(ch, n)) exp_q.push_back({2'(ch), 30'(n)});
        for (int k = 0; k < span; k++) begin
            chip_selection_button    = !(k < h_cs);
            increment_address_button = !(k < h_inc);
            decrement_address_button = !(k < h_dec);
            tick();
        end
    endtask

    initial begin
        int d, p, e;
        reset = 1'b1;
        chip_selection_button    = 1'b1;
        increment_address_button = 1'b1;
        decrement_address_button = 1'b1;
        chk_held = 1'b0;
        sc_d = 0;
        for (int ch = 0; ch < 3; ch++) sc_hold[ch] = 0;
        clear_counts();

        repeat (3) tick();
        check_val("reset_outputs",
                  int'({chip_selection_pulse, increment_pulse, decrement_pulse, buttons_held}), 0);
        check_val("reset_state", int'(channel_state), 0);
        reset = 1'b0;
        repeat (3) tick();

        vecs[0] = '{0,  10, 0,  0, 1, 0};  // clean press
        vecs[1] = '{0,  60, 0,  0, 9, 0};  // auto-repeat
        vecs[2] = '{0,  0,  30, 0, 0, 3};
        vecs[3] = '{100, 0, 0,  1, 0, 0};  // chip select never repeats
        vecs[4] = '{0,  0,  3,  0, 0, 0};  // glitch one short of debounce
        vecs[5] = '{0,  0,  4,  0, 0, 1};  // exactly debounce length
        vecs[6] = '{0,  40, 40, 0, 0, 0};  // interlock
        vecs[7] = '{0,  70, 40, 0, 6, 0};  // interlock then dec released
        vecs[8] = '{30, 30, 0,  1, 3, 0};

        chk_held = 1'b1;
        foreach (vecs[i]) begin
            clear_counts();
            run_scenario(vecs[i].h_cs, vecs[i].h_inc, vecs[i].h_dec);
            check_val($sformatf("count_cs_v%0d", i),  pulse_cnt[2], vecs[i].n_cs);
            check_val($sformatf("count_inc_v%0d", i), pulse_cnt[1], vecs[i].n_inc);
            check_val($sformatf("count_dec_v%0d", i), pulse_cnt[0], vecs[i].n_dec);
            repeat ($urandom_range(3, 8)) tick();
        end
        chk_held = 1'b0;

        // Bounce: 2-cycle toggles, then a steady press.
        clear_counts();
        d = cyc;
        exp_q.push_back({2'd0, 30'(d + 12 + LAT)});
        for (int k = 0; k < 12; k++) begin
            decrement_address_button = ((k / 2) % 2) != 0;
            tick();
        end
        decrement_address_button = 1'b0;
        repeat (20) tick();
        decrement_address_button = 1'b1;
        repeat (20) tick();
        check_val("bounce_count", pulse_cnt[0], 1);

        // Button held through reset yields one fresh press.
        clear_counts();
        reset = 1'b1;
        increment_address_button = 1'b0;
        repeat (4) tick();
        check_val("held_in_reset",
                  int'({chip_selection_pulse, increment_pulse, decrement_pulse, buttons_held}), 0);
        reset = 1'b0;
        e = cyc;
        exp_q.push_back({2'd1, 30'(e + LAT)});
        repeat (15) tick();
        increment_address_button = 1'b1;
        repeat (20) tick();
        check_val("held_through_reset_count", pulse_cnt[1], 1);

        // Reset pulsed mid-repeat aborts and restarts with a new press.
        clear_counts();
        d = cyc;
        p = d + LAT;
        exp_q.push_back({2'd1, 30'(p)});
        exp_q.push_back({2'd1, 30'(p + RD)});
        exp_q.push_back({2'd1, 30'(p + 29)});
        increment_address_button = 1'b0;
        while (cyc < p + 21) tick();
        reset = 1'b1;
        tick();
        check_val("mid_repeat_reset_outputs",
                  int'({chip_selection_pulse, increment_pulse, decrement_pulse, buttons_held}), 0);
        check_val("mid_repeat_reset_state", int'(channel_state), 0);
        reset = 1'b0;
        while (cyc < p + 28) tick();
        check_val("held_before_repress", int'(buttons_held), 0);
        tick();
        check_val("held_at_repress", int'(buttons_held), 2);
        while (cyc < p + 40) tick();
        increment_address_button = 1'b1;
        while (cyc < p + 60) tick();
        check_val("mid_repeat_count", pulse_cnt[1], 3);

        check_val("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
